// File: rtl/clock_run_control.sv
// Debouncer for one board input: 2-flop synchronizer followed by a hold-time filter.
// Latency: a stable level change reaches db_out 2 + DEBOUNCE_CYCLES cycles after it is applied.
// Backpressure: none; free-running on every inclk0 edge.
module clock_run_control_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic inclk0,
    input  logic reset_n,
    input  logic raw_in,
    output logic db_out
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          db_q,    db_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    // Count consecutive disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d  = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchronizer, debounced level and hold counter registers.
    always_ff @(posedge inclk0) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db_out = db_q;
endmodule

// Run / pause / single-step control of the divided processor clock, plus a c0 edge counter.
// Latency: locked and state follow the debounced inputs by one cycle; step_done coincides with locked rising.
// Backpressure: none; the divider is paused purely through the registered locked output.
module clock_run_control #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        inclk0,
    input  logic        reset_n,
    input  logic        run_sw,
    input  logic        step_btn,
    input  logic [7:0]  step_n,
    input  logic        c0_in,
    output logic        locked,
    output logic [1:0]  state,
    output logic        step_done,
    output logic [31:0] cycle_count
);
    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        STEP   = 2'd2
    } state_e;

    logic        run_db;
    logic        step_db;
    logic        step_db_prev_q, step_db_prev_d;
    logic        step_pulse;
    logic        c0_q, c0_d;
    logic        c0_rise;
    logic [31:0] cycle_count_q, cycle_count_d;

    state_e      state_q, state_d;
    logic [7:0]  remaining_q, remaining_d;
    logic        locked_q, locked_d;
    logic        step_done_q, step_done_d;

    clock_run_control_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_db (
        .inclk0  (inclk0),
        .reset_n (reset_n),
        .raw_in  (run_sw),
        .db_out  (run_db)
    );

    clock_run_control_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
        .inclk0  (inclk0),
        .reset_n (reset_n),
        .raw_in  (step_btn),
        .db_out  (step_db)
    );

    // c0_in is already in the inclk0 domain, so its edge is taken directly.
    assign step_pulse = step_db & ~step_db_prev_q;
    assign c0_rise    = c0_in & ~c0_q;

    // Edge-detect history and free-running processor cycle counter (wraps naturally).
    always_comb begin
        step_db_prev_d = step_db;
        c0_d           = c0_in;
        cycle_count_d  = cycle_count_q + {31'd0, c0_rise};
    end

    // Edge-detect and counter registers.
    always_ff @(posedge inclk0) begin
        if (!reset_n) begin
            step_db_prev_q <= 1'b0;
            c0_q           <= 1'b0;
            cycle_count_q  <= 32'd0;
        end else begin
            step_db_prev_q <= step_db_prev_d;
            c0_q           <= c0_d;
            cycle_count_q  <= cycle_count_d;
        end
    end

    // Next-state logic; run switch always wins over any step activity.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        step_done_d = 1'b0;
        case (state_q)
            PAUSED: begin
                if (run_db) begin
                    state_d = RUN;
                end else if (step_pulse && (step_n != 8'd0)) begin
                    state_d     = STEP;
                    remaining_d = step_n;
                end
            end
            RUN: begin
                if (!run_db) begin
                    state_d = PAUSED;
                end
            end
            STEP: begin
                if (run_db) begin
                    state_d = RUN;
                end else if (c0_rise) begin
                    if (remaining_q == 8'd1) begin
                        state_d     = PAUSED;
                        step_done_d = 1'b1;
                    end else begin
                        remaining_d = remaining_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = PAUSED;
            end
        endcase
        locked_d = (state_d == PAUSED);
    end

    // FSM state and its registered outputs.
    always_ff @(posedge inclk0) begin
        if (!reset_n) begin
            state_q     <= PAUSED;
            remaining_q <= 8'd0;
            locked_q    <= 1'b1;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            locked_q    <= locked_d;
            step_done_q <= step_done_d;
        end
    end

    assign locked      = locked_q;
    assign state       = state_q;
    assign step_done   = step_done_q;
    assign cycle_count = cycle_count_q;
endmodule

// File: tb/tb_clock_run_control.sv
// Scoreboard bench for clock_run_control: stimulus queues expected output changes, a monitor checks them.
// Latency: expected run/step transitions land 7 edges after the raw input is driven (2 sync + 4 debounce + 1 FSM).
// Backpressure: the bench divider model holds c0_in whenever locked is high.
module tb_clock_run_control;
    localparam int DB = 4;

    logic        inclk0 = 1'b0;
    logic        reset_n = 1'b0;
    logic        run_sw = 1'b0;
    logic        step_btn = 1'b0;
    logic [7:0]  step_n = 8'd0;
    logic        c0_in = 1'b0;
    logic        locked;
    logic [1:0]  state;
    logic        step_done;
    logic [31:0] cycle_count;

    clock_run_control #(.DEBOUNCE_CYCLES(DB)) dut (
        .inclk0      (inclk0),
        .reset_n     (reset_n),
        .run_sw      (run_sw),
        .step_btn    (step_btn),
        .step_n      (step_n),
        .c0_in       (c0_in),
        .locked      (locked),
        .state       (state),
        .step_done   (step_done),
        .cycle_count (cycle_count)
    );

    always #5 inclk0 = ~inclk0;

    localparam logic [1:0] S_PAUSED = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_STEP   = 2'd2;

    typedef struct {
        int         cyc;   // expected edge number, -1 = not timed
        logic [1:0] st;
        logic       lk;
        logic       done;
        int         n;     // processor edges expected within the finished step
    } ev_t;

    ev_t         exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;
    logic [31:0] rise_total = 32'd0;
    logic [31:0] step_base = 32'd0;
    logic [1:0]  prev_st = 2'd0;
    logic        prev_lk = 1'b1;
    int          phase = 0;

    always @(posedge inclk0) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic push(input int c, input logic [1:0] s, input logic l, input logic d, input int n);
        ev_t e;
        e.cyc  = c;
        e.st   = s;
        e.lk   = l;
        e.done = d;
        e.n    = n;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge inclk0);
            #1;
        end
    endtask

    // Divider model: c0_in toggles every 3 edges while unlocked, holds while locked, low in reset.
    always @(posedge inclk0) begin
        #2;
        if (!reset_n) begin
            c0_in      = 1'b0;
            phase      = 0;
            rise_total = 32'd0;
        end else if (locked) begin
            phase = 0;
        end else begin
            phase++;
            if (phase == 3) begin
                phase = 0;
                c0_in = ~c0_in;
                if (c0_in) rise_total = rise_total + 32'd1;
            end
        end
    end

    // Monitor: every change of state/locked or a step_done pulse must match the next queued expectation.
    always @(negedge inclk0) begin
        if (!mon_en) begin
            prev_st = S_PAUSED;
            prev_lk = 1'b1;
        end else if (state !== prev_st || locked !== prev_lk || step_done !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event: state=%0d locked=%0b step_done=%0b at edge %0d, none required",
                         state, locked, step_done, cyc);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.cyc >= 0) chk("event_edge", cyc, e.cyc);
                chk("state", {30'd0, state}, {30'd0, e.st});
                chk("locked", {31'd0, locked}, {31'd0, e.lk});
                chk("step_done", {31'd0, step_done}, {31'd0, e.done});
                chk("cycle_count", cycle_count, rise_total);
                if (e.done) chk("step_rises", rise_total - step_base, e.n);
            end
            if (state === S_STEP && prev_st !== S_STEP) step_base = rise_total;
            prev_st = state;
            prev_lk = locked;
        end
    end

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        chk("pending_events", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic set_run(input logic v, input logic [1:0] st);
        push(cyc + 7, st, (st == S_PAUSED), 1'b0, 0);
        run_sw = v;
    endtask

    // Optional glitch burst (highs of at most 3 cycles), then optionally a stable press and release.
    task automatic press(input int glitches, input bit settle, input bit expect_ev,
                         input logic [1:0] st, input int done_n);
        for (int g = 0; g < glitches; g++) begin
            step_btn = 1'b1;
            tick($urandom_range(1, 3));
            step_btn = 1'b0;
            tick($urandom_range(1, 2));
        end
        if (settle) begin
            if (expect_ev) begin
                push(cyc + 7, st, 1'b0, 1'b0, 0);
                if (done_n > 0) push(-1, S_PAUSED, 1'b1, 1'b1, done_n);
            end
            step_btn = 1'b1;
            tick(10);
        end
        step_btn = 1'b0;
        tick(8);
    endtask

    task automatic do_reset();
        mon_en   = 1'b0;
        reset_n  = 1'b0;
        run_sw   = 1'($urandom_range(0, 1));
        step_btn = 1'($urandom_range(0, 1));
        step_n   = 8'($urandom_range(0, 255));
        tick(3);
        chk("rst_locked", {31'd0, locked}, 32'd1);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_step_done", {31'd0, step_done}, 32'd0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        run_sw   = 1'b0;
        step_btn = 1'b0;
        reset_n  = 1'b1;
        mon_en   = 1'b1;
        tick(2);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        do_reset();
        tick(5);

        // Free run then pause
        set_run(1'b1, S_RUN);
        tick($urandom_range(30, 80));
        set_run(1'b0, S_PAUSED);
        wait_drain(30);
        tick(5);

        // Steps of random length, some with a bouncy press
        for (int i = 0; i < 4; i++) begin
            n = (i == 0) ? 1 : ((i == 1) ? 3 : int'($urandom_range(1, 6)));
            step_n = 8'(n);
            press((i == 3) ? 3 : 0, 1'b1, 1'b1, S_STEP, n);
            wait_drain(100);
            tick(3);
        end

        // Step disabled, then glitches without a stable press: no activity
        step_n = 8'd0;
        press(0, 1'b1, 1'b0, S_PAUSED, 0);
        step_n = 8'd5;
        press(4, 1'b0, 1'b0, S_PAUSED, 0);
        tick(10);
        chk("idle_queue", exp_q.size(), 0);

        // Run and press on the same cycle: press is dropped
        step_n = 8'd4;
        push(cyc + 7, S_RUN, 1'b0, 1'b0, 0);
        run_sw   = 1'b1;
        step_btn = 1'b1;
        tick(10);
        step_btn = 1'b0;
        tick($urandom_range(10, 30));
        set_run(1'b0, S_PAUSED);
        wait_drain(30);
        tick(5);

        // Long step: extra press mid-step, abort by run, extra press in run
        step_n = 8'd200;
        press(0, 1'b1, 1'b1, S_STEP, 0);
        tick(20);
        step_n = 8'd7;
        press(1, 1'b1, 1'b0, S_STEP, 0);
        set_run(1'b1, S_RUN);
        tick(12);
        press(0, 1'b1, 1'b0, S_RUN, 0);
        set_run(1'b0, S_PAUSED);
        wait_drain(30);
        tick(5);

        // Reset in the middle of a step
        step_n = 8'd200;
        press(0, 1'b1, 1'b1, S_STEP, 0);
        wait_drain(30);
        tick(10);
        do_reset();
        tick(5);

        // Counter wrap: preload near the top, then a 3-edge step
        force dut.cycle_count_d = 32'hFFFF_FFFE;
        tick(1);
        release dut.cycle_count_d;
        rise_total = 32'hFFFF_FFFE;
        tick(2);
        step_n = 8'd3;
        press(0, 1'b1, 1'b1, S_STEP, 3);
        wait_drain(100);
        chk("wrap_value", cycle_count, 32'h0000_0001);

        tick(5);
        chk("final_queue", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
